// File: rtl/ctrl_pkg.sv
// Shared encodings for the hardwired sequencer: states, opcodes, datapath select codes
// and the control bundle that drives every datapath control port.
package ctrl_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned RSEL_W   = 2;
    localparam int unsigned ONEHOT_W = 4;

    localparam bit HALT_ON_F = 1'b1;

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HALT    = 3'd4
    } ctrlState_t;

    localparam logic [OP_W-1:0] OP_LDI  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDM  = 4'h1;
    localparam logic [OP_W-1:0] OP_STM  = 4'h2;
    localparam logic [OP_W-1:0] OP_LDAR = 4'h3;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h5;
    localparam logic [OP_W-1:0] OP_AND  = 4'h6;
    localparam logic [OP_W-1:0] OP_OR   = 4'h7;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h8;
    localparam logic [OP_W-1:0] OP_INC  = 4'h9;
    localparam logic [OP_W-1:0] OP_DEC  = 4'hA;
    localparam logic [OP_W-1:0] OP_MOV  = 4'hB;
    localparam logic [OP_W-1:0] OP_BRA  = 4'hC;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'hD;
    localparam logic [OP_W-1:0] OP_BNE  = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

    localparam logic [1:0] FUN_CLEAR = 2'b00;
    localparam logic [1:0] FUN_LOAD  = 2'b01;
    localparam logic [1:0] FUN_DEC   = 2'b10;
    localparam logic [1:0] FUN_INC   = 2'b11;

    localparam logic [3:0] ALU_PASSA = 4'b0000;
    localparam logic [3:0] ALU_NOTA  = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IR  = 2'b10;
    localparam logic [1:0] MUX_ARF = 2'b11;

    localparam logic [1:0] ARF_PC = 2'b00;
    localparam logic [1:0] ARF_AR = 2'b01;
    localparam logic [1:0] ARF_SP = 2'b10;

    localparam logic [ONEHOT_W-1:0] ARF_EN_PC = 4'b1000;
    localparam logic [ONEHOT_W-1:0] ARF_EN_AR = 4'b0100;

    typedef struct packed {
        logic [2:0]          rfOutASel;
        logic [2:0]          rfOutBSel;
        logic [1:0]          rfFunSel;
        logic [ONEHOT_W-1:0] rfRSel;
        logic [ONEHOT_W-1:0] rfTSel;
        logic [3:0]          aluFunSel;
        logic [1:0]          arfOutCSel;
        logic [1:0]          arfOutDSel;
        logic [1:0]          arfFunSel;
        logic [ONEHOT_W-1:0] arfRegSel;
        logic                irLH;
        logic                irEnable;
        logic [1:0]          irFunsel;
        logic                memWR;
        logic                memCS;
        logic [1:0]          muxASel;
        logic [1:0]          muxBSel;
        logic                muxCSel;
    } ctrlBundle_t;

    // Every enable off, memory deselected (chip select is active-low).
    localparam ctrlBundle_t CTRL_IDLE = '{
        rfOutASel: 3'd0, rfOutBSel: 3'd0, rfFunSel: 2'd0, rfRSel: 4'd0, rfTSel: 4'd0,
        aluFunSel: 4'd0, arfOutCSel: 2'd0, arfOutDSel: 2'd0, arfFunSel: 2'd0,
        arfRegSel: 4'd0, irLH: 1'b0, irEnable: 1'b0, irFunsel: 2'd0, memWR: 1'b0,
        memCS: 1'b1, muxASel: 2'd0, muxBSel: 2'd0, muxCSel: 1'b0
    };

    // R1..R4 map to write-enable bits 3..0.
    function automatic logic [ONEHOT_W-1:0] regOneHot(input logic [RSEL_W-1:0] r);
        return ONEHOT_W'(4'b1000 >> r);
    endfunction

    function automatic logic isAluOp(input logic [OP_W-1:0] op);
        return (op >= OP_ADD && op <= OP_NOT) || op == OP_MOV;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode from sequencer state and instruction fields to the control bundle.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  ctrlState_t        state,
    input  logic [OP_W-1:0]   op,
    input  logic [RSEL_W-1:0] d,
    input  logic [RSEL_W-1:0] s,
    input  logic              zFlag,
    output ctrlBundle_t       ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            ST_RST: begin
                // PC is cleared to zero before the first fetch.
                ctrl.arfRegSel = ARF_EN_PC;
                ctrl.arfFunSel = FUN_CLEAR;
            end
            ST_FETCH_L, ST_FETCH_H: begin
                ctrl.arfOutDSel = ARF_PC;
                ctrl.memCS      = 1'b0;
                ctrl.irEnable   = 1'b1;
                ctrl.irFunsel   = FUN_LOAD;
                ctrl.irLH       = (state == ST_FETCH_H);
                ctrl.arfRegSel  = ARF_EN_PC;
                ctrl.arfFunSel  = FUN_INC;
            end
            ST_EXEC: begin
                case (op)
                    OP_LDI: begin
                        ctrl.muxASel  = MUX_IR;
                        ctrl.rfFunSel = FUN_LOAD;
                        ctrl.rfRSel   = regOneHot(d);
                    end
                    OP_LDM: begin
                        ctrl.arfOutDSel = ARF_AR;
                        ctrl.memCS      = 1'b0;
                        ctrl.muxASel    = MUX_MEM;
                        ctrl.rfFunSel   = FUN_LOAD;
                        ctrl.rfRSel     = regOneHot(d);
                    end
                    OP_STM: begin
                        ctrl.rfOutASel  = 3'({1'b0, d});
                        ctrl.muxCSel    = 1'b0;
                        ctrl.aluFunSel  = ALU_PASSA;
                        ctrl.arfOutDSel = ARF_AR;
                        ctrl.memCS      = 1'b0;
                        ctrl.memWR      = 1'b1;
                    end
                    OP_LDAR: begin
                        ctrl.muxBSel   = MUX_IR;
                        ctrl.arfRegSel = ARF_EN_AR;
                        ctrl.arfFunSel = FUN_LOAD;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: begin
                        ctrl.rfOutASel = 3'({1'b0, d});
                        ctrl.rfOutBSel = 3'({1'b0, s});
                        ctrl.muxCSel   = 1'b0;
                        case (op)
                            OP_ADD:  ctrl.aluFunSel = ALU_ADD;
                            OP_SUB:  ctrl.aluFunSel = ALU_SUB;
                            OP_AND:  ctrl.aluFunSel = ALU_AND;
                            OP_OR:   ctrl.aluFunSel = ALU_OR;
                            default: ctrl.aluFunSel = ALU_NOTA;
                        endcase
                        ctrl.muxASel  = MUX_ALU;
                        ctrl.rfFunSel = FUN_LOAD;
                        ctrl.rfRSel   = regOneHot(d);
                    end
                    OP_MOV: begin
                        ctrl.rfOutASel = 3'({1'b0, s});
                        ctrl.aluFunSel = ALU_PASSA;
                        ctrl.muxASel   = MUX_ALU;
                        ctrl.rfFunSel  = FUN_LOAD;
                        ctrl.rfRSel    = regOneHot(d);
                    end
                    OP_INC, OP_DEC: begin
                        ctrl.rfFunSel = (op == OP_INC) ? FUN_INC : FUN_DEC;
                        ctrl.rfRSel   = regOneHot(d);
                    end
                    OP_BRA, OP_BEQ, OP_BNE: begin
                        // Conditional branches use only the registered Z flag.
                        if (op == OP_BRA || (op == OP_BEQ && zFlag) || (op == OP_BNE && !zFlag)) begin
                            ctrl.muxBSel   = MUX_IR;
                            ctrl.arfRegSel = ARF_EN_PC;
                            ctrl.arfFunSel = FUN_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Hardwired three-cycle sequencer for the 8-bit datapath: state register, Z latch,
// and the decoded control outputs wired straight to the datapath ports.
module ctrl_unit
    import ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic [1:0]  SeqCount
);

    ctrlState_t        state;
    ctrlState_t        nextState;
    logic              zFlag;
    logic [OP_W-1:0]   op;
    logic [RSEL_W-1:0] d;
    logic [RSEL_W-1:0] s;
    ctrlBundle_t       decoded;
    ctrlBundle_t       ctrl;
    logic              unusedBits;

    assign op = IROut[15:12];
    assign d  = IROut[11:10];
    assign s  = IROut[9:8];

    // The immediate byte and the C/N/O flags go to the datapath, not the sequencer.
    assign unusedBits = ^{IROut[7:0], ALUOutFlag[2:0]};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_RST;
            zFlag <= 1'b0;
        end else begin
            state <= nextState;
            if (state == ST_EXEC && isAluOp(op)) begin
                zFlag <= ALUOutFlag[3];
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_RST:     nextState = ST_FETCH_L;
            ST_FETCH_L: nextState = ST_FETCH_H;
            ST_FETCH_H: nextState = ST_EXEC;
            ST_EXEC:    nextState = (HALT_ON_F && op == OP_HLT) ? ST_HALT : ST_FETCH_L;
            ST_HALT:    nextState = ST_HALT;
            default:    nextState = ST_RST;
        endcase
    end

    ctrl_decode uDecode (
        .state (state),
        .op    (op),
        .d     (d),
        .s     (s),
        .zFlag (zFlag),
        .ctrl  (decoded)
    );

    // While Reset is high the RST-state PC clear must not reach the datapath.
    assign ctrl = Reset ? CTRL_IDLE : decoded;

    assign RF_OutASel  = ctrl.rfOutASel;
    assign RF_OutBSel  = ctrl.rfOutBSel;
    assign RF_FunSel   = ctrl.rfFunSel;
    assign RF_RSel     = ctrl.rfRSel;
    assign RF_TSel     = ctrl.rfTSel;
    assign ALU_FunSel  = ctrl.aluFunSel;
    assign ARF_OutCSel = ctrl.arfOutCSel;
    assign ARF_OutDSel = ctrl.arfOutDSel;
    assign ARF_FunSel  = ctrl.arfFunSel;
    assign ARF_RegSel  = ctrl.arfRegSel;
    assign IR_LH       = ctrl.irLH;
    assign IR_Enable   = ctrl.irEnable;
    assign IR_Funsel   = ctrl.irFunsel;
    assign Mem_WR      = ctrl.memWR;
    assign Mem_CS      = ctrl.memCS;
    assign MuxASel     = ctrl.muxASel;
    assign MuxBSel     = ctrl.muxBSel;
    assign MuxCSel     = ctrl.muxCSel;

    assign Halted = (state == ST_HALT);

    always_comb begin
        SeqCount = 2'd0;
        case (state)
            ST_FETCH_H: SeqCount = 2'd1;
            ST_EXEC:    SeqCount = 2'd2;
            default:    SeqCount = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: walks reset, fetch, several executes, branches and halt.
module tb_ctrl_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;
    logic [1:0]  SeqCount;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    ctrl_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable),
        .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .Halted(Halted), .SeqCount(SeqCount)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // From EXEC: run T0 and T1, present the instruction, land in its EXEC cycle.
    task automatic runInstr(input logic [15:0] instr, input logic [3:0] flag);
        tick();
        tick();
        IROut      = instr;
        ALUOutFlag = flag;
        tick();
    endtask

    initial begin
        Reset      = 1'b1;
        IROut      = 16'h0000;
        ALUOutFlag = 4'h0;
        tick();
        tick();
        IROut = 16'h042A;
        #1;
        check("rst cs",     16'(Mem_CS),     16'h1);
        check("rst regsel", 16'(ARF_RegSel), 16'h0);
        check("rst irEn",   16'(IR_Enable),  16'h0);
        check("rst rsel",   16'(RF_RSel),    16'h0);
        check("rst seq",    16'(SeqCount),   16'h0);
        check("rst halted", 16'(Halted),     16'h0);

        // Release: one RST cycle clearing PC
        Reset = 1'b0;
        #1;
        check("RST regsel", 16'(ARF_RegSel), 16'h8);
        check("RST fun",    16'(ARF_FunSel), 16'h0);
        check("RST cs",     16'(Mem_CS),     16'h1);

        tick();
        check("T0 seq",    16'(SeqCount),    16'h0);
        check("T0 cs",     16'(Mem_CS),      16'h0);
        check("T0 irEn",   16'(IR_Enable),   16'h1);
        check("T0 irFun",  16'(IR_Funsel),   16'h1);
        check("T0 lh",     16'(IR_LH),       16'h0);
        check("T0 regsel", 16'(ARF_RegSel),  16'h8);
        check("T0 fun",    16'(ARF_FunSel),  16'h3);
        check("T0 outD",   16'(ARF_OutDSel), 16'h0);
        tick();
        check("T1 seq",    16'(SeqCount),    16'h1);
        check("T1 lh",     16'(IR_LH),       16'h1);
        check("T1 fun",    16'(ARF_FunSel),  16'h3);
        tick();
        check("LDI seq",   16'(SeqCount),    16'h2);
        check("LDI rsel",  16'(RF_RSel),     16'h4);
        check("LDI muxA",  16'(MuxASel),     16'h2);
        check("LDI rfFun", 16'(RF_FunSel),   16'h1);
        check("LDI cs",    16'(Mem_CS),      16'h1);
        check("LDI irEn",  16'(IR_Enable),   16'h0);

        // SUB R2,R3 with Z flag set
        runInstr(16'h5600, 4'b1000);
        check("SUB outA",  16'(RF_OutASel),  16'h1);
        check("SUB outB",  16'(RF_OutBSel),  16'h2);
        check("SUB alu",   16'(ALU_FunSel),  16'h6);
        check("SUB muxA",  16'(MuxASel),     16'h0);
        check("SUB rsel",  16'(RF_RSel),     16'h4);
        check("SUB muxC",  16'(MuxCSel),     16'h0);

        // BEQ taken on latched Z=1 even though the live flag is now 0
        runInstr(16'hD040, 4'b0000);
        check("BEQ1 muxB",   16'(MuxBSel),    16'h2);
        check("BEQ1 regsel", 16'(ARF_RegSel), 16'h8);
        check("BEQ1 fun",    16'(ARF_FunSel), 16'h1);

        // ADD clears Z
        runInstr(16'h4400, 4'b0000);
        check("ADD alu",   16'(ALU_FunSel),  16'h4);
        check("ADD outA",  16'(RF_OutASel),  16'h1);
        check("ADD outB",  16'(RF_OutBSel),  16'h0);

        // BEQ not taken: live flag set but latched Z is 0
        runInstr(16'hD040, 4'b1000);
        check("BEQ0 regsel", 16'(ARF_RegSel), 16'h0);
        check("BEQ0 muxB",   16'(MuxBSel),    16'h0);
        check("BEQ0 rsel",   16'(RF_RSel),    16'h0);
        check("BEQ0 cs",     16'(Mem_CS),     16'h1);

        runInstr(16'hE040, 4'b1000);
        check("BNE regsel", 16'(ARF_RegSel), 16'h8);
        check("BNE muxB",   16'(MuxBSel),    16'h2);

        runInstr(16'h2C00, 4'b0000);
        check("STM wr",    16'(Mem_WR),      16'h1);
        check("STM cs",    16'(Mem_CS),      16'h0);
        check("STM outD",  16'(ARF_OutDSel), 16'h1);
        check("STM outA",  16'(RF_OutASel),  16'h3);
        check("STM alu",   16'(ALU_FunSel),  16'h0);
        check("STM rsel",  16'(RF_RSel),     16'h0);

        runInstr(16'h9800, 4'b0000);
        check("INC fun",   16'(RF_FunSel),   16'h3);
        check("INC rsel",  16'(RF_RSel),     16'h2);

        runInstr(16'hB100, 4'b0000);
        check("MOV outA",  16'(RF_OutASel),  16'h1);
        check("MOV rsel",  16'(RF_RSel),     16'h8);

        runInstr(16'h3012, 4'b0000);
        check("LDAR regsel", 16'(ARF_RegSel), 16'h4);
        check("LDAR muxB",   16'(MuxBSel),    16'h2);

        // LDM, then reset in the middle of its EXEC cycle
        runInstr(16'h1C00, 4'b0000);
        check("LDM muxA",  16'(MuxASel),     16'h1);
        check("LDM outD",  16'(ARF_OutDSel), 16'h1);
        check("LDM rsel",  16'(RF_RSel),     16'h1);
        check("LDM cs",    16'(Mem_CS),      16'h0);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst cs",   16'(Mem_CS),   16'h1);
        check("midrst rsel", 16'(RF_RSel),  16'h0);
        check("midrst seq",  16'(SeqCount), 16'h0);
        tick();
        Reset = 1'b0;
        #1;
        check("midrst RST regsel", 16'(ARF_RegSel), 16'h8);
        check("midrst RST fun",    16'(ARF_FunSel), 16'h0);
        tick();
        check("midrst T0 seq",  16'(SeqCount),  16'h0);
        check("midrst T0 irEn", 16'(IR_Enable), 16'h1);

        // HLT
        tick();
        IROut = 16'hF000;
        tick();
        check("HLT exec halted", 16'(Halted),   16'h0);
        check("HLT exec seq",    16'(SeqCount), 16'h2);
        check("HLT exec cs",     16'(Mem_CS),   16'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("HALT halted", 16'(Halted),     16'h1);
            check("HALT cs",     16'(Mem_CS),     16'h1);
            check("HALT irEn",   16'(IR_Enable),  16'h0);
            check("HALT regsel", 16'(ARF_RegSel), 16'h0);
            check("HALT seq",    16'(SeqCount),   16'h0);
        end
        #2;
        Reset = 1'b1;
        #1;
        check("HALT rst halted", 16'(Halted), 16'h0);
        tick();
        Reset = 1'b0;
        #1;
        check("post RST regsel", 16'(ARF_RegSel), 16'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Hardwired sequencer that drives every control input of the 8-bit datapath: RF, ARF, IR, memory, ALU and MUX A/B/C.
- Fetches a 16-bit instruction as two 8-bit memory reads, then issues one execute cycle. Branches use a Z flag latched from the ALU.
- Sits beside the datapath; the top level wires its outputs one-to-one to the datapath control ports.

Parameters:
- PC_RESET, 8'h00, value PC holds after reset sequence (clear when 0, else loaded via MuxB=IR path is not used; fixed 0 this revision)
- HALT_ON_F, 1, opcode 4'hF halts the sequencer

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- IROut  in  16  instruction register contents
- ALUOutFlag  in  4  {Z,C,N,O}, bit3 = Z
- RF_OutASel, RF_OutBSel  out  3  RF read selects; 000..011 = R1..R4
- RF_FunSel  out  2  00 clear, 01 load, 10 dec, 11 inc
- RF_RSel  out  4  one-hot write enable; bit3 = R1 .. bit0 = R4
- RF_TSel  out  4  temp-register enables; always 0000
- ALU_FunSel  out  4  0000 passA, 0010 notA, 0100 add, 0110 sub, 0111 and, 1000 or
- ARF_OutCSel, ARF_OutDSel  out  2  00 PC, 01 AR, 10 SP
- ARF_FunSel  out  2  same encoding as RF_FunSel
- ARF_RegSel  out  4  one-hot; bit3 PC, bit2 AR, bit1 SP
- IR_LH  out  1  0 = low byte, 1 = high byte
- IR_Enable  out  1  IR write enable
- IR_Funsel  out  2  01 load
- Mem_WR  out  1  1 = write
- Mem_CS  out  1  active-low chip select
- MuxASel, MuxBSel  out  2  00 ALU, 01 Mem, 10 IR[7:0], 11 ARF_COut
- MuxCSel  out  1  0 = RF OutA, 1 = ARF_COut
- Halted  out  1  sequencer in HALT
- SeqCount  out  2  current T-state, 0..2

Behaviour:
- Instruction fields: op = IR[15:12], d = IR[11:10] (R1..R4), s = IR[9:8], imm = IR[7:0].
- States: RST, FETCH_L (T0), FETCH_H (T1), EXEC (T2), HALT. The state register and Z latch are the only flops.
- Idle outputs: all enables 0, Mem_CS = 1, Mem_WR = 0, every select 0.
- Reset asserted, including mid-instruction: state goes to RST immediately; outputs idle; Z = 0; Halted = 0.
- RST (one cycle after Reset deasserts): ARF_RegSel = PC, ARF_FunSel = clear; then go to FETCH_L.
- FETCH_L: ARF_OutDSel = PC, Mem_CS = 0, IR_Enable = 1, IR_Funsel = load, IR_LH = 0, ARF_RegSel = PC, ARF_FunSel = inc. Next state FETCH_H.
- FETCH_H: same as FETCH_L with IR_LH = 1. Next state EXEC.
- EXEC decodes IROut combinationally. Next state FETCH_L, or HALT for op F.
  - 0 LDI: MuxA = IR, RF load Rd.
  - 1 LDM: OutDSel = AR, Mem_CS = 0, MuxA = Mem, load Rd.
  - 2 STM: OutASel = d, MuxC = 0, ALU passA, OutDSel = AR, Mem_CS = 0, Mem_WR = 1.
  - 3 LDAR: MuxB = IR, ARF load AR.
  - 4/5/6/7 ADD/SUB/AND/OR: OutASel = d, OutBSel = s, MuxC = 0, ALU op, MuxA = ALU, load Rd.
  - 8 NOT: as ADD with the notA code.
  - B MOV: OutASel = s, passA, MuxA = ALU, load Rd.
  - 9 INC / A DEC: RF_FunSel inc/dec on Rd.
  - C BRA: MuxB = IR, load PC.
  - D BEQ / E BNE: as BRA only if Z = 1 / Z = 0; otherwise all enables idle.
  - F HLT: enter HALT.
- Z latch: captures ALUOutFlag[3] at the rising edge closing EXEC for ops 4–8 and B only; held otherwise.
- HALT: outputs idle, Halted = 1, stays until Reset.
- Timing: every instruction takes exactly 3 cycles. SeqCount = 0/1/2 in T0/T1/T2 and 0 in RST/HALT.
- Outputs are Moore from state plus IROut. No output depends on ALUOutFlag in the same cycle except the BEQ/BNE enables, which use the registered Z.

Decomposition:
- ctrl_pkg: state encoding; opcode constants; ALU, FunSel, MUX and ARF-select encodings; idle-output default values.
- One sub-module, ctrl_decode: combinational map from {state, op, d, s, Z} to the control bundle.
- ctrl_unit keeps the state register, the Z latch and the outputs Halted/SeqCount.

Test Plan:
- Reset pulse mid-EXEC, release -> one cycle RST (ARF_RegSel = 1000, FunSel = 00), then FETCH_L with SeqCount = 0; Mem_CS = 1 while Reset high.
- IROut = 16'h0_4_2A (LDI R2, 8'h2A) through T0..T2 -> T0/T1 IR_LH = 0/1 with PC inc; T2 RF_RSel = 0100, MuxASel = 10, RF_FunSel = 01.
- IROut = 16'h5_6_00 (SUB R2, R3) with ALUOutFlag = 4'b1000 -> T2 OutASel = 001, OutBSel = 010, ALU_FunSel = 0110; Z = 1 afterward.
- Following BEQ 16'hD0_40 -> T2 MuxBSel = 10, ARF_RegSel = 1000, ARF_FunSel = 01; with Z = 0 no enable asserted.
- STM 16'h2C_00 -> T2 Mem_WR = 1, Mem_CS = 0, OutDSel = 01, OutASel = 011.
- HLT 16'hF000 -> Halted = 1 from the next cycle and held for 10 cycles with idle outputs; Reset clears it.
